// File: rtl/pipe_hazard_pkg.sv
// Shared encodings for the pipeline hazard logic: forwarding-mux selects,
// Tnew/Tuse constants and the multiply/divide busy-length helper.
package pipe_hazard_pkg;

  localparam int PKG_T_W = 2;
  typedef logic [PKG_T_W-1:0] tval_t;

  localparam tval_t TNEW_NONE   = 2'd0;
  localparam tval_t TNEW_ALU    = 2'd1;
  localparam tval_t TNEW_LOAD   = 2'd2;
  localparam tval_t TUSE_BRANCH = 2'd0;
  localparam tval_t TUSE_ALU    = 2'd1;
  localparam tval_t TUSE_STORE  = 2'd2;

  localparam logic [1:0] FWD_D_RF = 2'b00;
  localparam logic [1:0] FWD_D_M  = 2'b01;
  localparam logic [1:0] FWD_D_E  = 2'b11;
  localparam logic [1:0] FWD_E_RF = 2'b00;
  localparam logic [1:0] FWD_E_M  = 2'b01;
  localparam logic [1:0] FWD_E_W  = 2'b10;

  typedef enum logic {MD_MULT = 1'b0, MD_DIV = 1'b1} md_kind_e;

  function automatic logic [7:0] md_load(input md_kind_e kind,
                                         input logic [7:0] mult_n,
                                         input logic [7:0] div_n);
    return (kind == MD_DIV) ? div_n : mult_n;
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Countdown of the remaining multiply/divide cycles; busy while non-zero.
module md_busy_tracker
  import pipe_hazard_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  localparam logic [7:0] MULT_N = 8'(MULT_CYC);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYC);

  logic [7:0] cnt_q, cnt_d;
  md_kind_e   kind;

  assign kind = div_i ? MD_DIV : MD_MULT;

  // A start arriving while busy is dropped; the D-stage MD stall prevents it.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i && (cnt_q == 8'd0)) begin
      cnt_d = md_load(kind, MULT_N, DIV_N);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != 8'd0);

endmodule

// File: rtl/hazard_unit_md.sv
// Stall/forward controller for the 5-stage pipeline with HI/LO busy tracking
// and a saturating stall-cycle counter.
module hazard_unit_md
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int T_W      = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [REG_AW-1:0] rs_D_i,
  input  logic [REG_AW-1:0] rt_D_i,
  input  logic              use_rs_D_i,
  input  logic              use_rt_D_i,
  input  logic [T_W-1:0]    tuse_rs_D_i,
  input  logic [T_W-1:0]    tuse_rt_D_i,
  input  logic [REG_AW-1:0] rs_E_i,
  input  logic [REG_AW-1:0] rt_E_i,
  input  logic [REG_AW-1:0] rt_M_i,
  input  logic [REG_AW-1:0] wreg_E_i,
  input  logic [REG_AW-1:0] wreg_M_i,
  input  logic [REG_AW-1:0] wreg_W_i,
  input  logic [T_W-1:0]    tnew_E_i,
  input  logic [T_W-1:0]    tnew_M_i,
  input  logic              md_op_D_i,
  input  logic              md_start_E_i,
  input  logic              md_div_E_i,
  input  logic              stat_clr_i,
  output logic [1:0]        fwd_rs_D_o,
  output logic [1:0]        fwd_rt_D_o,
  output logic [1:0]        fwd_rs_E_o,
  output logic [1:0]        fwd_rt_E_o,
  output logic              fwd_rt_M_o,
  output logic              stall_o,
  output logic              md_busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  function automatic logic match(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] wreg);
    return (src != '0) && (src == wreg);
  endfunction

  function automatic logic [1:0] fwd_d(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] wE,
                                       input logic [T_W-1:0]    tE,
                                       input logic [REG_AW-1:0] wM,
                                       input logic [T_W-1:0]    tM);
    if (match(src, wE) && (tE == '0))      return FWD_D_E;
    else if (match(src, wM) && (tM == '0)) return FWD_D_M;
    else                                   return FWD_D_RF;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] wM,
                                       input logic [T_W-1:0]    tM,
                                       input logic [REG_AW-1:0] wW);
    if (match(src, wM) && (tM == '0)) return FWD_E_M;
    else if (match(src, wW))          return FWD_E_W;
    else                              return FWD_E_RF;
  endfunction

  logic rs_stall, rt_stall, gpr_stall, md_stall, md_busy;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // A D-stage read stalls when a producer in E or M will not have its result in time.
  assign rs_stall = use_rs_D_i &&
                    ((match(rs_D_i, wreg_E_i) && (tuse_rs_D_i < tnew_E_i)) ||
                     (match(rs_D_i, wreg_M_i) && (tuse_rs_D_i < tnew_M_i)));
  assign rt_stall = use_rt_D_i &&
                    ((match(rt_D_i, wreg_E_i) && (tuse_rt_D_i < tnew_E_i)) ||
                     (match(rt_D_i, wreg_M_i) && (tuse_rt_D_i < tnew_M_i)));
  assign gpr_stall = rs_stall || rt_stall;

  md_busy_tracker #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_md_busy (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .start_i  (md_start_E_i),
    .div_i    (md_div_E_i),
    .busy_o   (md_busy)
  );

  assign md_stall  = md_op_D_i && (md_start_E_i || md_busy);
  assign stall_o   = gpr_stall || md_stall;
  assign md_busy_o = md_busy;

  assign fwd_rs_D_o = fwd_d(rs_D_i, wreg_E_i, tnew_E_i, wreg_M_i, tnew_M_i);
  assign fwd_rt_D_o = fwd_d(rt_D_i, wreg_E_i, tnew_E_i, wreg_M_i, tnew_M_i);
  assign fwd_rs_E_o = fwd_e(rs_E_i, wreg_M_i, tnew_M_i, wreg_W_i);
  assign fwd_rt_E_o = fwd_e(rt_E_i, wreg_M_i, tnew_M_i, wreg_W_i);
  assign fwd_rt_M_o = match(rt_M_i, wreg_W_i);

  // Clear takes precedence; the count sticks at all-ones once saturated.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr_i) begin
      stall_cnt_d = '0;
    end else if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
